// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the LEGv8 pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] XZR_IDX = 5'd31;

  // Values that flushed pipeline registers load in place of real content.
  localparam logic [31:0] NOP_INSN = 32'hD503201F;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_ZERO = '0;

  function automatic logic is_real_reg(input logic [4:0] r);
    return r != XZR_IDX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Pipeline status, memory handshake and stall/flush controls.
//               Perf-counter signals exist only with PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rn;
  logic [4:0]  id_rm;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_op;
  logic        mem_branch_taken;
  logic        dmem_ready;
  logic        dmem_req;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_flush;
  logic        ex_mem_write;
  logic        mem_wb_write;
  logic        mem_wb_bubble;
  logic        mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [31:0] loaduse_count;
`endif

  modport master (
`ifdef PIPE_CTRL_PERF_EN
    input  perf_clr,
    output stall_cycles, flush_count, loaduse_count,
`endif
    input  id_rn, id_rm, ex_memread, ex_rd, mem_op, mem_branch_taken, dmem_ready,
    output dmem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_mem_flush, ex_mem_write, mem_wb_write, mem_wb_bubble, mem_err
  );

  modport slave (
`ifdef PIPE_CTRL_PERF_EN
    output perf_clr,
    input  stall_cycles, flush_count, loaduse_count,
`endif
    output id_rn, id_rm, ex_memread, ex_rd, mem_op, mem_branch_taken, dmem_ready,
    input  dmem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_mem_flush, ex_mem_write, mem_wb_write, mem_wb_bubble, mem_err
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use compare between ID/EX load and ID sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import pipe_pkg::*;
(
  input  wire logic       i_ex_memread,
  input  wire logic [4:0] i_ex_rd,
  input  wire logic [4:0] i_id_rn,
  input  wire logic [4:0] i_id_rm,
  output logic            o_hazard
);

  // XZR reads as zero, so a load targeting it never feeds a consumer.
  assign o_hazard = i_ex_memread && is_real_reg(i_ex_rd) &&
                    ((i_ex_rd == i_id_rn) || (i_ex_rd == i_id_rm));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage LEGv8 pipeline with
//               data-memory wait handling. Optional macro: PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input  wire logic              clock,
  input  wire logic              reset,
  pipeline_hazard_ctrl_if.master bus
);

  localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_mem_err;
  logic            w_loaduse;
  logic            w_stall;
  logic            w_timeout;
  logic            w_dmem_req;
  logic            w_wb_bubble;
  logic            w_flush_apply;
  logic            w_lu_apply;

  hazard_detect u_hazard_detect (
    .i_ex_memread (bus.ex_memread),
    .i_ex_rd      (bus.ex_rd),
    .i_id_rn      (bus.id_rn),
    .i_id_rm      (bus.id_rm),
    .o_hazard     (w_loaduse)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_err <= w_timeout;
      if (r_state == MEM_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                     r_wait_cnt <= '0;
    end
  end

  // Reset forces the pass-through control set regardless of state.
  always_comb begin
    w_state_nxt = r_state;
    w_dmem_req  = 1'b0;
    w_stall     = 1'b0;
    w_timeout   = 1'b0;
    w_wb_bubble = 1'b0;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (bus.mem_op) begin
            w_dmem_req = 1'b1;
            if (!bus.dmem_ready) begin
              w_stall     = 1'b1;
              w_state_nxt = MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          w_dmem_req = bus.mem_op;
          if (bus.dmem_ready) begin
            w_state_nxt = RUN;
          end else if (r_wait_cnt == c_to_last) begin
            // Abandon the access and let it retire as a bubble.
            w_timeout   = 1'b1;
            w_wb_bubble = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_stall = 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // The release cycle is not a stall, so a held branch or hazard acts there.
  assign w_flush_apply = !reset && !w_stall && bus.mem_branch_taken;
  assign w_lu_apply    = !reset && !w_stall && !bus.mem_branch_taken && w_loaduse;

  assign bus.dmem_req      = w_dmem_req;
  assign bus.pc_write      = !w_stall && !w_lu_apply;
  assign bus.if_id_write   = !w_stall && !w_lu_apply;
  assign bus.if_id_flush   = w_flush_apply;
  assign bus.id_ex_bubble  = w_flush_apply || w_lu_apply;
  assign bus.ex_mem_flush  = w_flush_apply;
  assign bus.ex_mem_write  = !w_stall;
  assign bus.mem_wb_write  = !w_stall;
  assign bus.mem_wb_bubble = w_wb_bubble;
  assign bus.mem_err       = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;
  logic [31:0] r_loaduse_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_loaduse_count <= '0;
    end else if (bus.perf_clr) begin
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_loaduse_count <= '0;
    end else begin
      if ((r_state == MEM_WAIT) && !(&r_stall_cycles)) r_stall_cycles  <= r_stall_cycles + 1'b1;
      if (w_flush_apply && !(&r_flush_count))          r_flush_count   <= r_flush_count + 1'b1;
      if (w_lu_apply && !(&r_loaduse_count))           r_loaduse_count <= r_loaduse_count + 1'b1;
    end
  end

  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.flush_count   = r_flush_count;
  assign bus.loaduse_count = r_loaduse_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  // {dmem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble,
  //  ex_mem_flush, ex_mem_write, mem_wb_write, mem_wb_bubble, mem_err}
  localparam logic [9:0] C_NORM  = 10'b0110001100;
  localparam logic [9:0] C_LU    = 10'b0000101100;
  localparam logic [9:0] C_STALL = 10'b1000000000;
  localparam logic [9:0] C_REL   = 10'b1110001100;
  localparam logic [9:0] C_TO    = 10'b1110001110;
  localparam logic [9:0] C_ERR   = 10'b0110001101;
  localparam logic [9:0] C_BR    = 10'b0111111100;
  localparam logic [9:0] C_BRREL = 10'b1111111100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [9:0] ctrl;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  assign ctrl = {bus.dmem_req, bus.pc_write, bus.if_id_write, bus.if_id_flush,
                 bus.id_ex_bubble, bus.ex_mem_flush, bus.ex_mem_write,
                 bus.mem_wb_write, bus.mem_wb_bubble, bus.mem_err};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rn            = 5'd0;
    bus.id_rm            = 5'd0;
    bus.ex_memread       = 1'b0;
    bus.ex_rd            = 5'd0;
    bus.mem_op           = 1'b0;
    bus.mem_branch_taken = 1'b0;
    bus.dmem_ready       = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    idle_inputs();
`ifdef PIPE_CTRL_PERF_EN
    bus.perf_clr = 1'b0;
`endif
    bus.mem_op = 1'b1;
    @(negedge clk);
    check("reset_ctrl", ctrl, C_NORM);
    cyc();
    rst = 1'b0;
    bus.mem_op = 1'b0;
    @(negedge clk);
    check("idle", ctrl, C_NORM);

    // Load-use on Rn, then the bubble moves into EX
    cyc();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd1; bus.id_rn = 5'd1; bus.id_rm = 5'd3;
    @(negedge clk); check("lu_rn", ctrl, C_LU);
    cyc();
    bus.ex_memread = 1'b0;
    @(negedge clk); check("lu_after", ctrl, C_NORM);
    cyc();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd2; bus.id_rn = 5'd5; bus.id_rm = 5'd2;
    @(negedge clk); check("lu_rm", ctrl, C_LU);
    cyc();
    bus.ex_rd = 5'd31; bus.id_rn = 5'd31; bus.id_rm = 5'd31;
    @(negedge clk); check("lu_xzr", ctrl, C_NORM);

    // Memory wait: three not-ready cycles then ready
    cyc(); idle_inputs();
    bus.mem_op = 1'b1;
    @(negedge clk); check("mw_run", ctrl, C_STALL);
    cyc(); @(negedge clk); check("mw_wait0", ctrl, C_STALL);
    cyc(); @(negedge clk); check("mw_wait1", ctrl, C_STALL);
    cyc(); bus.dmem_ready = 1'b1;
    @(negedge clk); check("mw_ready", ctrl, C_REL);
    cyc(); idle_inputs();
    @(negedge clk); check("mw_after", ctrl, C_NORM);

    // Zero-wait access stays in RUN
    cyc(); bus.mem_op = 1'b1; bus.dmem_ready = 1'b1;
    @(negedge clk); check("zw_access", ctrl, C_REL);
    cyc(); idle_inputs();
    @(negedge clk); check("zw_after", ctrl, C_NORM);

    // Timeout: ready never arrives
    cyc(); bus.mem_op = 1'b1;
    @(negedge clk); check("to_run", ctrl, C_STALL);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk); check("to_wait", ctrl, C_STALL);
    end
    cyc(); @(negedge clk); check("to_release", ctrl, C_TO);
    cyc(); bus.mem_op = 1'b0;
    @(negedge clk); check("to_err_pulse", ctrl, C_ERR);
    cyc(); @(negedge clk); check("to_err_clear", ctrl, C_NORM);

    // Branch alone, then branch together with a load-use hazard
    cyc(); bus.mem_branch_taken = 1'b1;
    @(negedge clk); check("br_only", ctrl, C_BR);
    cyc(); bus.ex_memread = 1'b1; bus.ex_rd = 5'd4; bus.id_rn = 5'd4;
    @(negedge clk); check("br_and_lu", ctrl, C_BR);

    // Branch held through a memory wait, applied on release
    cyc(); idle_inputs();
    bus.mem_op = 1'b1; bus.mem_branch_taken = 1'b1;
    @(negedge clk); check("brw_run", ctrl, C_STALL);
    cyc(); @(negedge clk); check("brw_wait", ctrl, C_STALL);
    cyc(); bus.dmem_ready = 1'b1;
    @(negedge clk); check("brw_release", ctrl, C_BRREL);
    cyc(); idle_inputs();
    @(negedge clk); check("brw_after", ctrl, C_NORM);

`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", bus.stall_cycles, 32'd9);
    check("perf_flush", bus.flush_count, 32'd3);
    check("perf_lu", bus.loaduse_count, 32'd2);
    cyc(); bus.perf_clr = 1'b1;
    cyc(); bus.perf_clr = 1'b0;
    @(negedge clk);
    check("perf_clr_stall", bus.stall_cycles, 32'd0);
    check("perf_clr_flush", bus.flush_count, 32'd0);
`endif

    // Asynchronous reset in the middle of a memory wait
    cyc(); bus.mem_op = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("rst_wait_ctrl", ctrl, C_NORM);
`ifdef PIPE_CTRL_PERF_EN
    check("rst_wait_perf", bus.stall_cycles, 32'd0);
`endif
    cyc();
    rst = 1'b0;
    bus.mem_op = 1'b0;
    @(negedge clk); check("rst_wait_run", ctrl, C_NORM);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LEGv8 pipeline.
- Drives write-enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and applies taken-branch flushes resolved in MEM.
- Runs the req/ready handshake with a variable-latency data memory, freezing the pipeline while an access is outstanding.

Parameters:
- MEM_TIMEOUT, 64, max wait cycles for dmem_ready before abort; legal range 1..255.
- TO_W, 8, width of the wait counter.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_rn  in  5  Rn field of the instruction in ID.
- id_rm  in  5  Rm/Rt field of the instruction in ID.
- ex_memread  in  1  ID/EX holds a load.
- ex_rd  in  5  destination register of the ID/EX instruction.
- mem_op  in  1  EX/MEM holds a load or store.
- mem_branch_taken  in  1  branch resolved taken in MEM.
- dmem_ready  in  1  memory completes the current access this cycle.
- dmem_req  out  1  memory access request.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  IF/ID load NOP.
- id_ex_bubble  out  1  ID/EX load zero controls.
- ex_mem_flush  out  1  EX/MEM load zero controls.
- ex_mem_write  out  1  EX/MEM enable.
- mem_wb_write  out  1  MEM/WB enable.
- mem_wb_bubble  out  1  MEM/WB load RegWrite=0, MemtoReg=0.
- mem_err  out  1  one-cycle pulse on timeout.

Behaviour:
- FSM states: RUN, MEM_WAIT.
- State, wait counter and mem_err are registered; all other outputs are combinational from state and inputs.
- Reset (async): state=RUN, counter=0, mem_err=0.
  - Outputs during reset: enables=1, flushes/bubbles=0, dmem_req=0.
- RUN, mem_op=1: dmem_req=1.
  - If dmem_ready=1 in the same cycle: zero-wait, the pipeline advances normally.
  - Else: all enables (pc/if_id/ex_mem/mem_wb)=0, next state MEM_WAIT, counter cleared.
- MEM_WAIT: dmem_req=1 and all enables=0; counter increments each cycle.
  - dmem_ready=1: enables=1 this cycle, next state RUN.
  - counter==MEM_TIMEOUT-1 without ready: mem_err pulses next cycle, mem_wb_bubble=1 and enables=1 (the access is dropped as a bubble), next state RUN.
- Load-use (RUN, no memory stall): ex_memread && ex_rd!=31 && (ex_rd==id_rn || ex_rd==id_rm).
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle.
- Taken branch (RUN, no memory stall): if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; pc_write=1 (target loads).
- Priority: memory stall > branch flush > load-use.
  - Branch and load-use in the same cycle: branch only, pc_write=1.
  - A branch arriving during MEM_WAIT is held by the frozen pipeline and is applied on the release cycle.
- Register 31 (XZR) never creates a hazard.
- dmem_req is never asserted while mem_op=0.
- Reset mid-MEM_WAIT: immediate return to RUN, no mem_err.

Optional Feature:
- PIPE_CTRL_PERF_EN defined: adds 32-bit outputs stall_cycles, flush_count and loaduse_count.
  - stall_cycles counts MEM_WAIT cycles; flush_count counts taken-branch flushes; loaduse_count counts load-use bubbles.
  - All counters are reset to 0, saturate at all-ones, and clear on perf_clr (1-bit input).
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - XZR_IDX=5'd31;
  - NOP/zero-control constants used by the flushed registers.
- One natural sub-module: hazard_detect, the combinational load-use compare.
- FSM, counter and optional perf counters stay in the top module.

Test Plan:
- LDUR X1 then ADD X2,X1,X3: ex_memread=1, ex_rd=1, id_rn=1 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1, then normal flow.
- Same sequence with ex_rd=31, id_rn=31 -> no stall.
- mem_op=1, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles, enables low 3 cycles, restored on the ready cycle.
- mem_op=1, dmem_ready never high, MEM_TIMEOUT=4 -> mem_err pulses once, mem_wb_bubble=1 on the release cycle, state returns to RUN.
- mem_branch_taken and a load-use hazard in the same cycle -> if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1.
- reset asserted during MEM_WAIT -> state RUN and enables=1 immediately (asynchronous), mem_err=0; with PIPE_CTRL_PERF_EN defined, counters read 0.
